wb_stage: RTL

//  MEM/WB pipeline register plus writeback logic for the 5-stage RV32I core.
//  - Captures the MEM-stage result and extracts/extends load data.
//  - Selects the writeback value and drives the register file write port
//    (write_reg / write_data / regwrite). The register file commits on the following negedge.
//  - Also exports the WB-stage bypass for EX forwarding, plus a retired-instruction counter.

---
 rtl/wb_stage.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage: MEM/WB pipeline register and writeback logic for the RV32I core.
//
// Captures the MEM-stage result one cycle after it is presented, extracts and
// extends load data, selects the writeback value and drives the register file
// write port. The same flops feed the WB->EX forwarding path. A retired-
// instruction counter and a one-cycle load-error pulse are also produced.
//
// Parameters
//   CNT_W         width of the instret counter (wraps modulo 2^CNT_W)
//   LOAD_CHECK    1: flag misaligned / illegal loads; 0: no check
//
// Ports
//   clk_i              core clock, all state updates on posedge
//   rst_i              synchronous active-high reset
//   stall_i            MEM not ready: capture a bubble
//   mem_valid_i        MEM stage holds a real instruction
//   mem_rd_i           destination register index
//   mem_regwrite_i     instruction writes rd
//   mem_wb_sel_i       00 ALU, 01 load, 10 PC+4, 11 reserved (writes 0)
//   mem_alu_result_i   ALU result, also the load address
//   mem_pc_plus4_i     link value for JAL/JALR
//   mem_funct3_i       load type
//   mem_load_data_i    raw aligned data-memory word
//   write_reg_o        register file write index
//   write_data_o       register file write data
//   regwrite_o         register file write enable
//   fwd_valid_o        WB holds a live write (= regwrite_o)
//   fwd_rd_o           forwarding destination (= write_reg_o)
//   fwd_data_o         forwarding value (= write_data_o)
//   load_err_o         one-cycle pulse: misaligned or illegal load retired
//   instret_o          retired-instruction count
// -----------------------------------------------------------------------------
module wb_stage #(
   parameter int unsigned CNT_W      = 64,
   parameter bit          LOAD_CHECK = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stall_i,
   input  logic             mem_valid_i,
   input  logic [4:0]       mem_rd_i,
   input  logic             mem_regwrite_i,
   input  logic [1:0]       mem_wb_sel_i,
   input  logic [31:0]      mem_alu_result_i,
   input  logic [31:0]      mem_pc_plus4_i,
   input  logic [2:0]       mem_funct3_i,
   input  logic [31:0]      mem_load_data_i,
   output logic [4:0]       write_reg_o,
   output logic [31:0]      write_data_o,
   output logic             regwrite_o,
   output logic             fwd_valid_o,
   output logic [4:0]       fwd_rd_o,
   output logic [31:0]      fwd_data_o,
   output logic             load_err_o,
   output logic [CNT_W-1:0] instret_o
);

   localparam logic [1:0] SelAlu  = 2'b00;
   localparam logic [1:0] SelLoad = 2'b01;
   localparam logic [1:0] SelLink = 2'b10;

   localparam logic [2:0] F3Lb  = 3'b000;
   localparam logic [2:0] F3Lh  = 3'b001;
   localparam logic [2:0] F3Lw  = 3'b010;
   localparam logic [2:0] F3Lbu = 3'b100;
   localparam logic [2:0] F3Lhu = 3'b101;

   logic [4:0]       write_reg_q,  write_reg_d;
   logic [31:0]      write_data_q, write_data_d;
   logic             regwrite_q,   regwrite_d;
   logic             load_err_q,   load_err_d;
   logic [CNT_W-1:0] instret_q,    instret_d;

   logic [1:0]  lane;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_val;
   logic [31:0] wb_val;
   logic        err;
   logic        capture;

   // Load lane extraction and extension
   always_comb begin
      lane = mem_alu_result_i[1:0];

      load_byte = mem_load_data_i[7:0];
      case (lane)
         2'd0:    load_byte = mem_load_data_i[7:0];
         2'd1:    load_byte = mem_load_data_i[15:8];
         2'd2:    load_byte = mem_load_data_i[23:16];
         default: load_byte = mem_load_data_i[31:24];
      endcase

      load_half = lane[1] ? mem_load_data_i[31:16] : mem_load_data_i[15:0];

      // Illegal funct3 codes pass the raw word through; only seen for debug.
      load_val = mem_load_data_i;
      case (mem_funct3_i)
         F3Lb:    load_val = {{24{load_byte[7]}}, load_byte};
         F3Lh:    load_val = {{16{load_half[15]}}, load_half};
         F3Lw:    load_val = mem_load_data_i;
         F3Lbu:   load_val = {24'h0, load_byte};
         F3Lhu:   load_val = {16'h0, load_half};
         default: load_val = mem_load_data_i;
      endcase
   end

   // Misaligned / illegal load detection
   always_comb begin
      err = 1'b0;
      if (LOAD_CHECK && (mem_wb_sel_i == SelLoad)) begin
         case (mem_funct3_i)
            F3Lh, F3Lhu:         err = lane[0];
            F3Lw:                err = (lane != 2'd0);
            F3Lb, F3Lbu:         err = 1'b0;
            default:             err = 1'b1;
         endcase
      end
   end

   // Writeback select and next-state
   always_comb begin
      case (mem_wb_sel_i)
         SelAlu:  wb_val = mem_alu_result_i;
         SelLoad: wb_val = load_val;
         SelLink: wb_val = mem_pc_plus4_i;
         default: wb_val = 32'h0;
      endcase

      capture = ~stall_i & mem_valid_i;

      // Bubbles hold the write index/data so the port stays quiet.
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      regwrite_d   = 1'b0;
      load_err_d   = 1'b0;
      instret_d    = instret_q;

      if (capture) begin
         write_reg_d  = mem_rd_i;
         write_data_d = wb_val;
         regwrite_d   = mem_regwrite_i & (mem_rd_i != 5'd0) & ~err;
         load_err_d   = err;
         // Every non-faulting instruction retires, whether or not it writes rd.
         if (!err) begin
            instret_d = instret_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         write_reg_q  <= 5'd0;
         write_data_q <= 32'h0;
         regwrite_q   <= 1'b0;
         load_err_q   <= 1'b0;
         instret_q    <= '0;
      end else begin
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
         regwrite_q   <= regwrite_d;
         load_err_q   <= load_err_d;
         instret_q    <= instret_d;
      end
   end

   assign write_reg_o  = write_reg_q;
   assign write_data_o = write_data_q;
   assign regwrite_o   = regwrite_q;
   assign fwd_valid_o  = regwrite_q;
   assign fwd_rd_o     = write_reg_q;
   assign fwd_data_o   = write_data_q;
   assign load_err_o   = load_err_q;
   assign instret_o    = instret_q;

endmodule
